// File: rtl/ripple_add.sv
// ---------------------------------------------------------------------------
// ripple_add
//   Parameterizable ripple-carry adder with registered result and flags.
//   A chain of WIDTH full-adder cells propagates the carry from bit 0 to
//   bit WIDTH-1. The sum, carry-out, signed overflow and zero flag are
//   captured on a rising clock edge when in_valid is high, which gives one
//   cycle of latency. When in_valid is low the result registers hold their
//   value and out_valid drops.
//
// Parameters
//   WIDTH      operand / sum width in bits (1..64), default 4
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      qualifies A/B/Cin for capture on this edge
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   Cin        in   1      carry into bit 0
//   Sum        out  WIDTH  registered sum
//   Cout       out  1      registered carry out of the MSB cell
//   Ovf        out  1      registered two's-complement overflow
//   Zero       out  1      registered flag, high when Sum == 0
//   out_valid  out  1      high while the outputs hold a freshly captured
//                          result
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// ripple_add_fa
//   Single 1-bit full-adder cell used as the building block of the chain.
//
// Ports
//   a, b       in   1  operand bits
//   cin        in   1  carry in from the previous (less significant) cell
//   sum        out  1  sum bit
//   cout       out 1  carry to the next (more significant) cell
// ---------------------------------------------------------------------------
module ripple_add_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half_sum_s;

    assign half_sum_s = a ^ b;
    assign sum        = half_sum_s ^ cin;
    // Generate when both bits are set, propagate an incoming carry otherwise.
    assign cout       = (a & b) | (cin & half_sum_s);

endmodule

module ripple_add #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero,
    output logic             out_valid
);

    // Reduction helper kept as a function so the zero test reads as intent.
    function automatic logic is_zero(input logic [WIDTH-1:0] value);
        return (value == {WIDTH{1'b0}});
    endfunction

    // carry_s[i] is the carry into cell i; carry_s[WIDTH] is the carry out.
    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    logic             ovf_s;
    logic             zero_s;

    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;
    logic             out_valid_r;

    assign carry_s[0] = Cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            ripple_add_fa u_fa (
                .a    (A[gi]),
                .b    (B[gi]),
                .cin  (carry_s[gi]),
                .sum  (sum_s[gi]),
                .cout (carry_s[gi+1])
            );
        end
    endgenerate

    // Signed overflow: carry into the sign cell differs from carry out of it.
    // For WIDTH == 1 the carry into the sign cell is Cin itself.
    assign ovf_s  = carry_s[WIDTH] ^ carry_s[WIDTH-1];
    assign zero_s = is_zero(sum_s);

    // Result and flag registers: capture on valid input, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r       <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (in_valid) begin
            sum_r       <= sum_s;
            cout_r      <= carry_s[WIDTH];
            ovf_r       <= ovf_s;
            zero_r      <= zero_s;
            out_valid_r <= 1'b1;
        end else begin
            sum_r       <= sum_r;
            cout_r      <= cout_r;
            ovf_r       <= ovf_r;
            zero_r      <= zero_r;
            out_valid_r <= 1'b0;
        end
    end

    assign Sum       = sum_r;
    assign Cout      = cout_r;
    assign Ovf       = ovf_r;
    assign Zero      = zero_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_ripple_add.sv
// ---------------------------------------------------------------------------
// tb_ripple_add
//   Self-checking bench for ripple_add. Three instances (WIDTH 4, 8 and 1)
//   share clock and reset. Expected values come from an arithmetic model of
//   the adder (integer add, signed range test for overflow) and from the
//   directed vector table.
// ---------------------------------------------------------------------------
module tb_ripple_add;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // WIDTH = 4 instance
    logic       in_valid_4, cin_4, cout_4, ovf_4, zero_4, out_valid_4;
    logic [3:0] a_4, b_4, sum_4;
    // WIDTH = 8 instance
    logic       in_valid_8, cin_8, cout_8, ovf_8, zero_8, out_valid_8;
    logic [7:0] a_8, b_8, sum_8;
    // WIDTH = 1 instance
    logic       in_valid_1, cin_1, cout_1, ovf_1, zero_1, out_valid_1;
    logic [0:0] a_1, b_1, sum_1;

    ripple_add #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_4),
        .A(a_4), .B(b_4), .Cin(cin_4),
        .Sum(sum_4), .Cout(cout_4), .Ovf(ovf_4), .Zero(zero_4),
        .out_valid(out_valid_4)
    );

    ripple_add #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8),
        .A(a_8), .B(b_8), .Cin(cin_8),
        .Sum(sum_8), .Cout(cout_8), .Ovf(ovf_8), .Zero(zero_8),
        .out_valid(out_valid_8)
    );

    ripple_add #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1),
        .A(a_1), .B(b_1), .Cin(cin_1),
        .Sum(sum_1), .Cout(cout_1), .Ovf(ovf_1), .Zero(zero_1),
        .out_valid(out_valid_1)
    );

    int checks_s = 0;
    int fails_s  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_s++;
        if (obs !== exp) begin
            fails_s++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: exact unsigned sum in w+1 bits, signed overflow
    // as "true signed result outside the w-bit two's-complement range".
    task automatic ref_add(input int w, input longint a, input longint b, input bit cin,
                           output longint sum, output bit cout, output bit ovf, output bit zero);
        longint one;
        longint full;
        longint sa;
        longint sb;
        longint sr;
        one  = 64'sd1;
        full = a + b + longint'(cin);
        sum  = full & ((one << w) - one);
        cout = ((full >> w) & one) != 0;
        sa   = (a >= (one << (w - 1))) ? a - (one << w) : a;
        sb   = (b >= (one << (w - 1))) ? b - (one << w) : b;
        sr   = sa + sb + longint'(cin);
        ovf  = (sr > (one << (w - 1)) - one) || (sr < -(one << (w - 1)));
        zero = (sum == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed table: {a[3:0], b[3:0], cin, sum[3:0], cout, ovf, zero}
    logic [15:0] dir_tab [10] = '{
        {4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1},
        {4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0},
        {4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0},
        {4'b0011, 4'b0101, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b0},
        {4'b0100, 4'b0011, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0},
        {4'b1100, 4'b0111, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0},
        {4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0},
        {4'b1011, 4'b1000, 1'b0, 4'b0011, 1'b1, 1'b1, 1'b0},
        {4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0},
        {4'b1010, 4'b0010, 1'b1, 4'b1101, 1'b0, 1'b0, 1'b0}
    };

    task automatic check4_zero(input string tag);
        check_eq({tag, "_sum"},  64'(sum_4), 64'd0);
        check_eq({tag, "_cout"}, 64'(cout_4), 64'd0);
        check_eq({tag, "_ovf"},  64'(ovf_4), 64'd0);
        check_eq({tag, "_zero"}, 64'(zero_4), 64'd0);
        check_eq({tag, "_ovld"}, 64'(out_valid_4), 64'd0);
    endtask

    initial begin
        logic [15:0] row;
        logic [8:0]  iv;
        longint      e_sum;
        bit          e_cout, e_ovf, e_zero;
        longint      l_sum;
        bit          l_cout, l_ovf, l_zero, vld;

        rst_n = 1'b0;
        in_valid_4 = 1'b0; a_4 = 4'd0; b_4 = 4'd0; cin_4 = 1'b0;
        in_valid_8 = 1'b0; a_8 = 8'd0; b_8 = 8'd0; cin_8 = 1'b0;
        in_valid_1 = 1'b0; a_1 = 1'b0; b_1 = 1'b0; cin_1 = 1'b0;

        #1;
        check4_zero("reset");
        #11;
        rst_n = 1'b1;
        tick();
        check4_zero("post_rst_idle");
        tick();
        check4_zero("post_rst_idle2");

        // Directed vectors, one per cycle.
        for (int i = 0; i < 10; i++) begin
            row = dir_tab[i];
            a_4 = row[15:12]; b_4 = row[11:8]; cin_4 = row[7];
            in_valid_4 = 1'b1;
            tick();
            check_eq($sformatf("dir%0d_sum", i),  64'(sum_4), 64'(row[6:3]));
            check_eq($sformatf("dir%0d_cout", i), 64'(cout_4), 64'(row[2]));
            check_eq($sformatf("dir%0d_ovf", i),  64'(ovf_4), 64'(row[1]));
            check_eq($sformatf("dir%0d_zero", i), 64'(zero_4), 64'(row[0]));
            check_eq($sformatf("dir%0d_ovld", i), 64'(out_valid_4), 64'd1);
        end

        // Hold: outputs keep 1101 while inputs toggle with in_valid low.
        in_valid_4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_4 = 4'($urandom); b_4 = 4'($urandom); cin_4 = 1'($urandom);
            tick();
            check_eq("hold_ovld", 64'(out_valid_4), 64'd0);
            check_eq("hold_sum",  64'(sum_4), 64'hd);
            check_eq("hold_cout", 64'(cout_4), 64'd0);
            check_eq("hold_ovf",  64'(ovf_4), 64'd0);
            check_eq("hold_zero", 64'(zero_4), 64'd0);
        end

        // Reset mid-cycle with a valid vector pending: in-flight result lost.
        a_4 = 4'b1111; b_4 = 4'b0001; cin_4 = 1'b0; in_valid_4 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check4_zero("async_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        in_valid_4 = 1'b0;
        tick();
        check4_zero("rst_discard");

        // Exhaustive WIDTH=4, back-to-back.
        for (int i = 0; i < 512; i++) begin
            iv = i[8:0];
            a_4 = iv[3:0]; b_4 = iv[7:4]; cin_4 = iv[8];
            in_valid_4 = 1'b1;
            ref_add(4, longint'(iv[3:0]), longint'(iv[7:4]), iv[8], e_sum, e_cout, e_ovf, e_zero);
            tick();
            check_eq($sformatf("ex4_%0d_sum", i),  64'(sum_4), 64'(e_sum));
            check_eq($sformatf("ex4_%0d_cout", i), 64'(cout_4), 64'(e_cout));
            check_eq($sformatf("ex4_%0d_ovf", i),  64'(ovf_4), 64'(e_ovf));
            check_eq($sformatf("ex4_%0d_zero", i), 64'(zero_4), 64'(e_zero));
            check_eq($sformatf("ex4_%0d_ovld", i), 64'(out_valid_4), 64'd1);
        end
        in_valid_4 = 1'b0;

        // WIDTH=8 random sweep with random gaps in in_valid.
        l_sum = 0; l_cout = 1'b0; l_ovf = 1'b0; l_zero = 1'b0;
        for (int i = 0; i < 400; i++) begin
            vld = ($urandom_range(0, 3) != 0);
            a_8 = 8'($urandom); b_8 = 8'($urandom); cin_8 = 1'($urandom);
            if (i % 50 == 0) begin
                a_8 = 8'hff; b_8 = 8'h00; cin_8 = 1'b1; vld = 1'b1;
            end
            in_valid_8 = vld;
            if (vld) begin
                ref_add(8, longint'(a_8), longint'(b_8), cin_8, l_sum, l_cout, l_ovf, l_zero);
            end
            tick();
            check_eq($sformatf("r8_%0d_sum", i),  64'(sum_8), 64'(l_sum));
            check_eq($sformatf("r8_%0d_cout", i), 64'(cout_8), 64'(l_cout));
            check_eq($sformatf("r8_%0d_ovf", i),  64'(ovf_8), 64'(l_ovf));
            check_eq($sformatf("r8_%0d_zero", i), 64'(zero_8), 64'(l_zero));
            check_eq($sformatf("r8_%0d_ovld", i), 64'(out_valid_8), 64'(vld));
        end
        in_valid_8 = 1'b0;

        // WIDTH=1 exhaustive: overflow reduces to Cout ^ Cin.
        for (int i = 0; i < 8; i++) begin
            iv = i[8:0];
            a_1 = iv[0]; b_1 = iv[1]; cin_1 = iv[2];
            in_valid_1 = 1'b1;
            ref_add(1, longint'(iv[0]), longint'(iv[1]), iv[2], e_sum, e_cout, e_ovf, e_zero);
            tick();
            check_eq($sformatf("w1_%0d_sum", i),  64'(sum_1), 64'(e_sum));
            check_eq($sformatf("w1_%0d_cout", i), 64'(cout_1), 64'(e_cout));
            check_eq($sformatf("w1_%0d_ovf", i),  64'(ovf_1), 64'(e_ovf));
            check_eq($sformatf("w1_%0d_zero", i), 64'(zero_1), 64'(e_zero));
            check_eq($sformatf("w1_%0d_ovld", i), 64'(out_valid_1), 64'd1);
        end
        in_valid_1 = 1'b0;
        tick();
        check_eq("w1_idle_ovld", 64'(out_valid_1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_s, fails_s);
        $finish;
    end

endmodule
